// File: rtl/cpu_mem_complete.sv
// cpu_mem_complete: p4 memory-completion stage (bus wait, load align, writeback).
// Bus timeout fault is built only when MEM_TIMEOUT_EN is defined.
module cpu_mem_complete #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        p3_request,
    input  logic        p3_write,
    input  logic [1:0]  p3_size,
    input  logic        p3_signed,
    input  logic [1:0]  p3_addr_lsb,
    input  logic [4:0]  p3_dest,
    input  logic        p3_wb_en,
    input  logic [31:0] p4_alu_out,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_error,
    output logic        mem_stall,
    output logic        p4_wb_valid,
    output logic [4:0]  p4_wb_dest,
    output logic [31:0] p4_wb_data,
    output logic        p4_mem_fault,
    output logic        p4_fault_is_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  lsb_q;
    logic [4:0]  dest_q;

    logic        waiting;
    logic        issue;
    logic        rd_ok;
    logic        ack_err;
    logic        alu_wb;
    logic        timeout;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    logic        wb_valid_q;
    logic [4:0]  wb_dest_q;
    logic [31:0] wb_data_q;
    logic        alu_pend_q;
    logic        fault_q;

    assign waiting = (state != IDLE);
    // The ack cycle frees upstream, so a new request there is accepted.
    assign issue   = p3_request & (!waiting | bus_ack);
    assign rd_ok   = (state == WAIT_RD) & bus_ack & !bus_error;
    assign ack_err = waiting & bus_ack & bus_error;
    assign alu_wb  = !waiting & !p3_request & p3_wb_en;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;
    logic        to_flag;

    assign timeout = waiting & !bus_ack & (wait_cnt == TO_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (issue) begin
            wait_cnt <= '0;
        end else if (waiting & !bus_ack) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            to_flag <= 1'b0;
        end else begin
            to_flag <= timeout;
        end
    end

    assign p4_fault_is_timeout = to_flag;
`else
    assign timeout             = 1'b0;
    assign p4_fault_is_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (issue) begin
            state_nxt = p3_write ? WAIT_WR : WAIT_RD;
        end else if (waiting & (bus_ack | timeout)) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        mem_stall = waiting & !bus_ack;
    end

    always_comb begin
        unique case (lsb_q)
            2'd0: byte_lane = bus_rdata[7:0];
            2'd1: byte_lane = bus_rdata[15:8];
            2'd2: byte_lane = bus_rdata[23:16];
            2'd3: byte_lane = bus_rdata[31:24];
        endcase
        half_lane = lsb_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (size_q)
            2'b00:   load_data = {{24{sign_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{16{sign_q & half_lane[15]}}, half_lane};
            default: load_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            size_q <= '0;
            sign_q <= 1'b0;
            lsb_q  <= '0;
            dest_q <= '0;
        end else if (issue) begin
            size_q <= p3_size;
            sign_q <= p3_signed;
            lsb_q  <= p3_addr_lsb;
            dest_q <= p3_dest;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            alu_pend_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            wb_valid_q <= rd_ok | alu_wb;
            alu_pend_q <= alu_wb;
            fault_q    <= ack_err | timeout;
            if (rd_ok) begin
                wb_dest_q <= dest_q;
                wb_data_q <= load_data;
            end else if (alu_wb) begin
                wb_dest_q <= p3_dest;
            end else if (alu_pend_q) begin
                wb_data_q <= p4_alu_out;
            end
        end
    end

    // ALU result is only valid once the instruction sits in p4.
    assign p4_wb_valid  = wb_valid_q;
    assign p4_wb_dest   = wb_dest_q;
    assign p4_wb_data   = alu_pend_q ? p4_alu_out : wb_data_q;
    assign p4_mem_fault = fault_q;

endmodule

// File: tb/tb_cpu_mem_complete.sv
// Scoreboard bench for cpu_mem_complete: random bus traffic vs. reference model.
// Timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_cpu_mem_complete;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        p3_request = 1'b0;
    logic        p3_write = 1'b0;
    logic [1:0]  p3_size = '0;
    logic        p3_signed = 1'b0;
    logic [1:0]  p3_addr_lsb = '0;
    logic [4:0]  p3_dest = '0;
    logic        p3_wb_en = 1'b0;
    logic [31:0] p4_alu_out = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_error = 1'b0;
    logic        mem_stall;
    logic        p4_wb_valid;
    logic [4:0]  p4_wb_dest;
    logic [31:0] p4_wb_data;
    logic        p4_mem_fault;
    logic        p4_fault_is_timeout;

    cpu_mem_complete #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock),
        .resetn(resetn),
        .p3_request(p3_request),
        .p3_write(p3_write),
        .p3_size(p3_size),
        .p3_signed(p3_signed),
        .p3_addr_lsb(p3_addr_lsb),
        .p3_dest(p3_dest),
        .p3_wb_en(p3_wb_en),
        .p4_alu_out(p4_alu_out),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata),
        .bus_error(bus_error),
        .mem_stall(mem_stall),
        .p4_wb_valid(p4_wb_valid),
        .p4_wb_dest(p4_wb_dest),
        .p4_wb_data(p4_wb_data),
        .p4_mem_fault(p4_mem_fault),
        .p4_fault_is_timeout(p4_fault_is_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          sg;
        logic [1:0]  lsb;
        logic [4:0]  dst;
        int          waits;
        logic [31:0] rdata;
        bit          err;
        bit          chain;
        bit          tmo;
    } op_t;

    typedef struct {
        bit          fault;
        bit          to;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    op_t  ops[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] ref_load(input int unsigned sz,
                                             input bit sg,
                                             input int unsigned lsb,
                                             input logic [31:0] rdata);
        int unsigned v;
        int unsigned r;
        r = rdata;
        if (sz == 0) begin
            v = (r >> (8 * lsb)) % 256;
            if (sg && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (r >> (16 * (lsb / 2))) % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input op_t o, input bit push);
        exp_t e;
        p3_request  = 1'b1;
        p3_write    = o.wr;
        p3_size     = o.sz;
        p3_signed   = o.sg;
        p3_addr_lsb = o.lsb;
        p3_dest     = o.dst;
        p3_wb_en    = 1'b0;
        e.fault = o.err | o.tmo;
        e.to    = o.tmo;
        e.dest  = o.dst;
        e.data  = ref_load(o.sz, o.sg, o.lsb, o.rdata);
        if (push && (e.fault || !o.wr)) sb.push_back(e);
    endtask

    task automatic alu_op(input logic [4:0] d, input logic [31:0] v);
        exp_t e;
        p3_wb_en   = 1'b1;
        p3_dest    = d;
        p4_alu_out = v;
        e.fault = 1'b0;
        e.to    = 1'b0;
        e.dest  = d;
        e.data  = v;
        sb.push_back(e);
        step();
        p3_wb_en = 1'b0;
        step();
        p4_alu_out = $urandom;
    endtask

    task automatic stray_ack();
        bus_ack   = 1'b1;
        bus_rdata = $urandom;
        bus_error = 1'($urandom % 2);
        step();
        bus_ack   = 1'b0;
        bus_error = 1'b0;
    endtask

    task automatic gap();
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
            if ($urandom % 2) alu_op(5'($urandom), $urandom);
            else stray_ack();
        end
    endtask

    // Monitor: pops the scoreboard whenever the stage presents a result.
    initial begin
        exp_t        e;
        logic [4:0]  last_dest = '0;
        logic [31:0] last_data = '0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                last_dest = '0;
                last_data = '0;
            end else if (p4_wb_valid || p4_mem_fault) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: got valid=%0b fault=%0b dest=%0d data=%h expected none",
                             p4_wb_valid, p4_mem_fault, p4_wb_dest, p4_wb_data);
                end else begin
                    e = sb.pop_front();
                    if (e.fault) begin
                        if (!(p4_mem_fault && !p4_wb_valid &&
                              p4_fault_is_timeout == e.to)) begin
                            n_bad++;
                            $display("FAIL fault: got fault=%0b valid=%0b to=%0b expected fault=1 valid=0 to=%0b",
                                     p4_mem_fault, p4_wb_valid, p4_fault_is_timeout, e.to);
                        end
                    end else if (!(p4_wb_valid && !p4_mem_fault &&
                                   p4_wb_dest == e.dest &&
                                   p4_wb_data == e.data)) begin
                        n_bad++;
                        $display("FAIL writeback: got valid=%0b fault=%0b dest=%0d data=%h expected dest=%0d data=%h",
                                 p4_wb_valid, p4_mem_fault, p4_wb_dest, p4_wb_data,
                                 e.dest, e.data);
                    end
                end
                if (p4_wb_valid) begin
                    last_dest = p4_wb_dest;
                    last_data = p4_wb_data;
                end
            end else begin
                chk("hold_data", p4_wb_data, last_data);
                chk("hold_dest", 32'(p4_wb_dest), 32'(last_dest));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_valid", 32'(p4_wb_valid), 0);
        chk("rst_dest", 32'(p4_wb_dest), 0);
        chk("rst_data", p4_wb_data, 0);
        chk("rst_fault", 32'(p4_mem_fault), 0);
        chk("rst_to", 32'(p4_fault_is_timeout), 0);
        step();

        ops.push_back('{0, 2'b00, 1, 2'd2, 5'd7,  3, 32'h12F4_5678, 0, 0, 0});
        ops.push_back('{0, 2'b01, 0, 2'd2, 5'd8,  0, 32'h8001_ABCD, 0, 0, 0});
        ops.push_back('{0, 2'b01, 1, 2'd2, 5'd9,  0, 32'h8001_ABCD, 0, 0, 0});
        ops.push_back('{1, 2'b10, 0, 2'd0, 5'd10, 1, 32'h0000_0000, 0, 1, 0});
        ops.push_back('{0, 2'b10, 0, 2'd0, 5'd11, 2, 32'hDEAD_BEEF, 0, 0, 0});
        ops.push_back('{0, 2'b10, 0, 2'd0, 5'd12, 1, 32'h1234_5678, 1, 0, 0});
`ifdef MEM_TIMEOUT_EN
        ops.push_back('{0, 2'b10, 0, 2'd0, 5'd13, 0, 32'h0, 0, 0, 1});
`endif
        for (int k = 0; k < 80; k++) begin
            o.wr    = ($urandom % 3) == 0;
            o.sz    = 2'($urandom);
            o.sg    = 1'($urandom);
            o.lsb   = 2'($urandom);
            o.dst   = 5'($urandom);
            o.waits = $urandom_range(0, 2);
            o.rdata = $urandom;
            o.err   = ($urandom % 8) == 0;
            o.chain = 1'($urandom);
            o.tmo   = 1'b0;
`ifdef MEM_TIMEOUT_EN
            o.tmo = ($urandom % 16) == 0;
`endif
            ops.push_back(o);
        end

        set_req(ops[0], 1);
        for (int i = 0; i < ops.size(); i++) begin
            step();
            p3_request = 1'b0;
            bus_ack    = 1'b0;
            bus_error  = 1'b0;
            if (ops[i].tmo) begin
                repeat (TO) begin
                    @(negedge clock);
                    chk("stall_tmo", 32'(mem_stall), 1);
                    step();
                end
                @(negedge clock);
                chk("stall_after_tmo", 32'(mem_stall), 0);
                step();
                stray_ack();
                gap();
                if (i + 1 < ops.size()) set_req(ops[i+1], 1);
                continue;
            end
            for (int w = 0; w < ops[i].waits; w++) begin
                p3_request = 1'($urandom);
                p3_write   = 1'($urandom);
                @(negedge clock);
                chk("stall_wait", 32'(mem_stall), 1);
                step();
            end
            p3_request = 1'b0;
            bus_ack    = 1'b1;
            bus_rdata  = ops[i].rdata;
            bus_error  = ops[i].err;
            if (ops[i].chain && i + 1 < ops.size()) set_req(ops[i+1], 1);
            @(negedge clock);
            chk("stall_ack", 32'(mem_stall), 0);
            if (ops[i].chain && i + 1 < ops.size()) continue;
            step();
            p3_request = 1'b0;
            bus_ack    = 1'b0;
            bus_error  = 1'b0;
            bus_rdata  = $urandom;
            gap();
            if (i + 1 < ops.size()) set_req(ops[i+1], 1);
        end
        step();

        // Reset in the middle of a load: the late ack must be dropped.
        o = '{0, 2'b10, 0, 2'd0, 5'd20, 0, 32'hCAFE_F00D, 0, 0, 0};
        set_req(o, 0);
        step();
        p3_request = 1'b0;
        step();
        resetn = 1'b0;
        #1;
        chk("rstmid_stall", 32'(mem_stall), 0);
        chk("rstmid_valid", 32'(p4_wb_valid), 0);
        chk("rstmid_dest", 32'(p4_wb_dest), 0);
        chk("rstmid_data", p4_wb_data, 0);
        chk("rstmid_fault", 32'(p4_mem_fault), 0);
        step();
        resetn    = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        chk("late_ack_stall", 32'(mem_stall), 0);
        step();
        bus_ack = 1'b0;
        alu_op(5'd3, 32'h0000_0005);
        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_complete.md
Name: cpu_mem_complete

Overview:
- Memory-completion stage (p4), directly downstream of the execute stage.
- Captures each data-bus request issued in p3 and holds the pipeline stall until the bus acknowledges.
- Aligns and sign/zero-extends load data, then presents a single writeback result (load data or the p4 ALU result) with destination register.
- Reports bus errors and, optionally, bus timeouts as a memory fault.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for bus_ack before a timeout fault (only with MEM_TIMEOUT_EN). Legal range 1..65535.

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- p3_request  in  1  bus request from execute; already gated by stall and jump nullify
- p3_write  in  1  1 = store, 0 = load
- p3_size  in  2  00 byte, 01 halfword, 10 word
- p3_signed  in  1  1 = sign-extend load (LDB/LDH), 0 = zero-extend (LDBU/LDHU)
- p3_addr_lsb  in  2  p3_addr[1:0] of the request
- p3_dest  in  5  destination register of the instruction in p3
- p3_wb_en  in  1  instruction in p3 writes a register (non-load)
- p4_alu_out  in  32  registered ALU result from execute
- bus_ack  in  1  bus completion: read data valid or write accepted, one-cycle pulse
- bus_rdata  in  32  read data, valid when bus_ack and transaction is a load
- bus_error  in  1  bus completion with error; qualifies bus_ack
- mem_stall  out  1  pipeline stall request while a transaction is outstanding
- p4_wb_valid  out  1  writeback strobe, one cycle
- p4_wb_dest  out  5  writeback register
- p4_wb_data  out  32  writeback data
- p4_mem_fault  out  1  one-cycle pulse on bus error/timeout
- p4_fault_is_timeout  out  1  qualifies p4_mem_fault: 1 = timeout, 0 = bus_error

Behaviour:
- Reset (resetn low, async): state IDLE, all outputs 0, captured fields 0, timeout counter 0. Reset mid-transaction abandons it silently; a late bus_ack after reset is ignored (arrives in IDLE).
- States: IDLE, WAIT_RD, WAIT_WR.
- IDLE:
  - p3_request & !p3_write → WAIT_RD.
  - p3_request & p3_write → WAIT_WR.
  - On either transition, capture size, signed, addr_lsb, dest.
  - !p3_request & p3_wb_en → next cycle p4_wb_valid=1, p4_wb_dest=captured dest, p4_wb_data=p4_alu_out (one-cycle latency, aligned with p4_alu_out).
- mem_stall = (state != IDLE) & !bus_ack. Combinational, so the stall drops in the same cycle as the ack.
- WAIT_RD on bus_ack & !bus_error: next cycle p4_wb_valid=1, p4_wb_data=extracted data.
  - Byte: lane = addr_lsb (bits [8*lsb+7:8*lsb]).
  - Halfword: lane = addr_lsb[1] (bits [16*lsb1+15:16*lsb1]).
  - Word: bus_rdata unchanged.
  - Extension: sign-extend if signed, else zero-extend. p3_size=11 is treated as word.
- WAIT_WR on bus_ack & !bus_error: no writeback; returns to IDLE.
- bus_ack & bus_error, either wait state: next cycle p4_mem_fault=1, p4_fault_is_timeout=0, no writeback, → IDLE.
- Back-to-back: in the bus_ack cycle, p3_request is honoured. The state goes directly to the new wait state with new fields captured; the completing writeback still issues from the old fields.
- bus_ack while IDLE: ignored, no output change.
- p3_request while in a wait state without bus_ack: ignored (illegal; upstream is stalled).
- p4_wb_valid and p4_mem_fault are pulses, never high together. p4_wb_data/dest hold their last value when valid is low.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 16-bit counter clears on entry to a wait state and increments each wait cycle without bus_ack.
  - When it reaches TIMEOUT_CYCLES: next cycle p4_mem_fault=1, p4_fault_is_timeout=1, → IDLE, mem_stall released.
  - A bus_ack in the same cycle as the timeout wins.
- Not defined:
  - No counter; waits indefinitely.
  - p4_fault_is_timeout is tied to 0.

Test Plan:
- LDB signed, lsb=2, bus_rdata=0x12F45678, ack after 3 wait cycles → mem_stall high exactly 3 cycles, then p4_wb_data=0xFFFFFFF4, p4_wb_valid one cycle, dest correct.
- LDHU lsb=2, rdata=0x8001ABCD, ack same cycle as issue+1 → p4_wb_data=0x00008001; LDH same → 0xFFFF8001.
- STW followed by LDW issued in the STW ack cycle, rdata=0xDEADBEEF → no writeback for store; load writeback 0xDEADBEEF; no bubble between transactions.
- LDW with bus_ack & bus_error → p4_mem_fault=1, p4_fault_is_timeout=0, p4_wb_valid=0, returns to IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → stall high 4 cycles, then p4_mem_fault=1, p4_fault_is_timeout=1; a later stray ack is ignored.
- Assert resetn low during WAIT_RD → all outputs 0 immediately; ack after release produces no writeback; ALU op with p3_wb_en=1, p4_alu_out=0x00000005 → p4_wb_data=5.
